// File: rtl/barrel_shifter.sv
// barrel_shifter
// ---------------------------------------------------------------------------
// Registered 32-bit barrel shifter for the execute stage. It performs a logical
// left, logical right, arithmetic right or rotate right of a 32-bit operand by
// 0..31 positions. The result appears on q one clock after the operands are
// accepted.
//
// Ports
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset; clears q and out_valid
//   in_valid  in   1  capture the operands on this edge
//   a         in  32  operand to shift
//   shift     in   5  shift distance 0..31, unsigned
//   op        in   2  00 lsl, 01 lsr, 10 asr, 11 ror (or lsr, see below)
//   q         out 32  registered result
//   out_valid out  1  high for one cycle when q holds a new result
//
// Configuration macro: BARREL_SHIFTER_ROTATE_EN
//   defined   : op=11 performs rotate right
//   undefined : the rotate logic is left out and op=11 behaves as op=01
// ---------------------------------------------------------------------------
module barrel_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [4:0]  shift,
    input  logic [1:0]  op,
    output logic [31:0] q,
    output logic        out_valid
);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // Reverses the bit order. Mirroring the operand and the result around the
    // right-shift network turns that network into a left shifter.
    function automatic logic [31:0] bit_reverse(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31 - i];
        end
        return r;
    endfunction

    logic        is_left;
    logic        fill;
    logic        rotate;
    logic [31:0] net_in;
    logic [31:0] st1;
    logic [31:0] st2;
    logic [31:0] st4;
    logic [31:0] st8;
    logic [31:0] st16;
    logic [31:0] result;

    // Decode the operation into controls for one shared right-shift network.
    // The fill bit is the value shifted into the vacated upper positions.
    // When rotating, the bits shifted out are wrapped around instead.
    always_comb begin
        is_left = 1'b0;
        fill    = 1'b0;
        rotate  = 1'b0;
        case (op)
            OP_LSL: is_left = 1'b1;
            OP_LSR: fill    = 1'b0;
            OP_ASR: fill    = a[31];
`ifdef BARREL_SHIFTER_ROTATE_EN
            OP_ROR: rotate  = 1'b1;
`else
            OP_ROR: fill    = 1'b0;
`endif
            default: fill   = 1'b0;
        endcase
        net_in = is_left ? bit_reverse(a) : a;
    end

    // Five logarithmic stages. Each shift bit selects one fixed distance, so a
    // shift of 0 passes the operand through untouched. No stage ever needs a
    // shift by 32.
`ifdef BARREL_SHIFTER_ROTATE_EN
    always_comb begin
        st1  = shift[0] ? {(rotate ? net_in[0]    : fill),      net_in[31:1]} : net_in;
        st2  = shift[1] ? {(rotate ? st1[1:0]     : {2{fill}}),  st1[31:2]}   : st1;
        st4  = shift[2] ? {(rotate ? st2[3:0]     : {4{fill}}),  st2[31:4]}   : st2;
        st8  = shift[3] ? {(rotate ? st4[7:0]     : {8{fill}}),  st4[31:8]}   : st4;
        st16 = shift[4] ? {(rotate ? st8[15:0]    : {16{fill}}), st8[31:16]}  : st8;
    end
`else
    always_comb begin
        st1  = shift[0] ? {fill,       net_in[31:1]} : net_in;
        st2  = shift[1] ? {{2{fill}},  st1[31:2]}    : st1;
        st4  = shift[2] ? {{4{fill}},  st2[31:4]}    : st2;
        st8  = shift[3] ? {{8{fill}},  st4[31:8]}    : st4;
        st16 = shift[4] ? {{16{fill}}, st8[31:16]}   : st8;
    end
`endif

    // Undo the input mirror for left shifts.
    always_comb begin
        result = is_left ? bit_reverse(st16) : st16;
    end

    // Output register. q only loads on accepted operands, so it holds its value
    // (and ignores any X on idle inputs) while in_valid is low. out_valid is the
    // one-cycle-delayed in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= 32'h0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                q <= result;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter.sv
// tb_barrel_shifter
// ---------------------------------------------------------------------------
// Directed testbench for barrel_shifter with hand-computed expected values.
// Rotate expectations follow BARREL_SHIFTER_ROTATE_EN the same way the design
// does.
// ---------------------------------------------------------------------------
module tb_barrel_shifter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [4:0]  shift;
    logic [1:0]  op;
    logic [31:0] q;
    logic        out_valid;

    int total;
    int bad;

    barrel_shifter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .shift     (shift),
        .op        (op),
        .q         (q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge, then return 1 ns after
    // the following rising edge so the outputs can be sampled.
    task automatic drive(input logic [31:0] av, input logic [4:0] sv,
                         input logic [1:0] ov, input logic v);
        @(negedge clk);
        a        = av;
        shift    = sv;
        op       = ov;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 32'h0;
        shift    = 5'd0;
        op       = 2'b00;
        #12;
        total++;
        if (q !== 32'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: q=%h out_valid=%b, expected q=00000000 out_valid=0", q, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lsr;
        logic [4:0]  sh  [6] = '{5'd0, 5'd1, 5'd4, 5'd8, 5'd16, 5'd31};
        logic [31:0] exp [6] = '{32'hF000DEAD, 32'h78006F56, 32'h0F000DEA,
                                 32'h00F000DE, 32'h0000F000, 32'h00000001};
        for (int i = 0; i < 6; i++) begin
            drive(32'hF000DEAD, sh[i], 2'b01, 1'b1);
            total++;
            if (q !== exp[i] || out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL lsr_s%0d: q=%h out_valid=%b, expected q=%h out_valid=1", sh[i], q, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_asr;
        logic [31:0] av  [5] = '{32'hF000DEAD, 32'hF000DEAD, 32'hF000DEAD, 32'hF000DEAD, 32'h7000DEAD};
        logic [4:0]  sh  [5] = '{5'd1, 5'd4, 5'd16, 5'd31, 5'd4};
        logic [31:0] exp [5] = '{32'hF8006F56, 32'hFF000DEA, 32'hFFFFF000, 32'hFFFFFFFF, 32'h07000DEA};
        for (int i = 0; i < 5; i++) begin
            drive(av[i], sh[i], 2'b10, 1'b1);
            total++;
            if (q !== exp[i] || out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL asr_%h_s%0d: q=%h out_valid=%b, expected q=%h", av[i], sh[i], q, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_ror;
        logic [4:0]  sh  [5] = '{5'd0, 5'd4, 5'd8, 5'd16, 5'd31};
`ifdef BARREL_SHIFTER_ROTATE_EN
        logic [31:0] exp [5] = '{32'hF000DEAD, 32'hDF000DEA, 32'hADF000DE, 32'hDEADF000, 32'hE001BD5B};
`else
        logic [31:0] exp [5] = '{32'hF000DEAD, 32'h0F000DEA, 32'h00F000DE, 32'h0000F000, 32'h00000001};
`endif
        for (int i = 0; i < 5; i++) begin
            drive(32'hF000DEAD, sh[i], 2'b11, 1'b1);
            total++;
            if (q !== exp[i] || out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL op11_s%0d: q=%h out_valid=%b, expected q=%h", sh[i], q, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_lsl;
        logic [4:0]  sh  [5] = '{5'd0, 5'd1, 5'd4, 5'd16, 5'd31};
        logic [31:0] exp [5] = '{32'hF000DEAD, 32'hE001BD5A, 32'h000DEAD0, 32'hDEAD0000, 32'h80000000};
        for (int i = 0; i < 5; i++) begin
            drive(32'hF000DEAD, sh[i], 2'b00, 1'b1);
            total++;
            if (q !== exp[i] || out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL lsl_s%0d: q=%h out_valid=%b, expected q=%h", sh[i], q, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [4:0]  sh  [3] = '{5'd2, 5'd12, 5'd20};
        logic [31:0] exp [3] = '{32'h3C0037AB, 32'h000F000D, 32'h00000F00};
        // Leave a gap first so out_valid is known low before the burst.
        drive(32'h0, 5'd0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(32'hF000DEAD, sh[i], 2'b01, 1'b1);
            total++;
            if (q !== exp[i] || out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b_%0d: q=%h out_valid=%b, expected q=%h out_valid=1", i, q, out_valid, exp[i]);
            end
        end
        // Idle with changing (even unknown) operands: q must hold.
        drive(32'h12345678, 5'd3, 2'b00, 1'b0);
        total++;
        if (q !== 32'h00000F00 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold_1: q=%h out_valid=%b, expected q=00000F00 out_valid=0", q, out_valid);
        end
        drive(32'hxxxxxxxx, 5'bxxxxx, 2'bxx, 1'b0);
        total++;
        if (q !== 32'h00000F00 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold_x: q=%h out_valid=%b, expected q=00000F00 out_valid=0", q, out_valid);
        end
    endtask

    task automatic test_async_reset;
        drive(32'hF000DEAD, 5'd4, 2'b00, 1'b1);
        in_valid = 1'b0;
        total++;
        if (q !== 32'h000DEAD0) begin
            bad++;
            $display("[TB] FAIL pre_reset_load: q=%h, expected 000DEAD0", q);
        end
        // Pull reset mid-cycle, well clear of any clock edge, with an op in flight.
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (q !== 32'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: q=%h out_valid=%b, expected q=00000000 out_valid=0", q, out_valid);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        total++;
        if (q !== 32'h0 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_discard: q=%h out_valid=%b, expected q=00000000 out_valid=0", q, out_valid);
        end
        drive(32'hF000DEAD, 5'd8, 2'b10, 1'b1);
        in_valid = 1'b0;
        total++;
        if (q !== 32'hFFF000DE || out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL post_reset_op: q=%h out_valid=%b, expected q=FFF000DE out_valid=1", q, out_valid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_lsr();
        test_asr();
        test_ror();
        test_lsl();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
